// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - handshake/bus bundle between instruction fetch and its host
interface inst_fetch_if #(
    parameter int INST_CAP = 5,
    parameter int INST_LEN = 17
);
    localparam int PC_W = $clog2(INST_CAP) + 1;

    logic                start;
    logic [PC_W-1:0]     prog_len;
    logic                ld_en;
    logic [PC_W-1:0]     ld_addr;
    logic [INST_LEN-1:0] ld_data;
    logic                redirect;
    logic [PC_W-1:0]     redirect_pc;
    logic [INST_LEN-1:0] inst;
    logic [PC_W-1:0]     inst_pc;
    logic                inst_valid;
    logic                inst_ready;
    logic                busy;
    logic                done;

    modport master (
        output start, prog_len, ld_en, ld_addr, ld_data, redirect, redirect_pc, inst_ready,
        input  inst, inst_pc, inst_valid, busy, done
    );

    modport slave (
        input  start, prog_len, ld_en, ld_addr, ld_data, redirect, redirect_pc, inst_ready,
        output inst, inst_pc, inst_valid, busy, done
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: small instruction RAM, run FSM, redirect and backpressure
module inst_fetch #(
    parameter int INST_CAP = 5,
    parameter int INST_LEN = 17
) (
    input  logic         clk,
    input  logic         rstn,
    inst_fetch_if.slave  bus
);
    localparam int PC_W = $clog2(INST_CAP) + 1;
    localparam int AW   = (INST_CAP > 1) ? $clog2(INST_CAP) : 1;
    localparam logic [PC_W-1:0] CAP_PC = PC_W'(INST_CAP);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     limit;
    logic [INST_LEN-1:0] mem [INST_CAP];
    logic [INST_LEN-1:0] inst_q;
    logic [PC_W-1:0]     inst_pc_q;
    logic                inst_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                update;

    assign update         = !inst_valid_q || bus.inst_ready;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // No reset on the array: program contents survive a reset.
    always_ff @(posedge clk) begin
        if (bus.ld_en && (bus.ld_addr < CAP_PC))
            mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            pc           <= '0;
            limit        <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pc     <= '0;
                        limit  <= (bus.prog_len > CAP_PC) ? CAP_PC : bus.prog_len;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.redirect) begin
                        // Out-of-range targets park pc at limit so the next cycle ends the run.
                        inst_valid_q <= 1'b0;
                        pc <= (bus.redirect_pc >= limit) ? limit : bus.redirect_pc;
                    end else if (update) begin
                        if (pc < limit) begin
                            inst_q       <= mem[pc[AW-1:0]];
                            inst_pc_q    <= pc;
                            inst_valid_q <= 1'b1;
                            pc           <= pc + PC_W'(1);
                        end else begin
                            inst_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
